// File: rtl/fir_ss_framer_if.sv
// Stream bundle between the raw-sample source, the framer and the FIR ss_* port.
// The framer takes the slave view; the environment (source + FIR) takes the master view.
interface fir_ss_framer_if #(
   parameter int pDATA_WIDTH = 32
);
   logic                   in_tvalid;
   logic [pDATA_WIDTH-1:0] in_tdata;
   logic                   in_tready;
   logic                   ss_tvalid;
   logic [pDATA_WIDTH-1:0] ss_tdata;
   logic                   ss_tlast;
   logic                   ss_tready;

   modport master (
      output in_tvalid, in_tdata, ss_tready,
      input  in_tready, ss_tvalid, ss_tdata, ss_tlast
   );

   modport slave (
      input  in_tvalid, in_tdata, ss_tready,
      output in_tready, ss_tvalid, ss_tdata, ss_tlast
   );
endinterface

// File: rtl/fir_ss_framer.sv
// Feeds the FIR ss_* port: buffers raw samples in a small FIFO and frames exactly
// cfg_len of them per run, marking the last one with ss_tlast.
module fir_ss_framer #(
   parameter int pDATA_WIDTH = 32,
   parameter int pDEPTH      = 4,
   parameter int pLEN_WIDTH  = 32
) (
   input  logic                  axis_clk,
   input  logic                  axis_rst,
   input  logic [pLEN_WIDTH-1:0] cfg_len,
   input  logic                  cfg_start,
   output logic                  busy,
   output logic                  frame_done,
   fir_ss_framer_if.slave        bus
);

   localparam int AW = $clog2(pDEPTH);
   localparam logic [AW:0]           OCC_FULL = (AW+1)'(pDEPTH);
   localparam logic [AW:0]           OCC_ZERO = (AW+1)'(0);
   localparam logic [AW:0]           OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]         PTR_ZERO = AW'(0);
   localparam logic [AW-1:0]         PTR_ONE  = AW'(1);
   localparam logic [pLEN_WIDTH-1:0] LEN_ZERO = pLEN_WIDTH'(0);
   localparam logic [pLEN_WIDTH-1:0] LEN_ONE  = pLEN_WIDTH'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [pLEN_WIDTH-1:0]   len_r;
   logic [pLEN_WIDTH-1:0]   in_cnt_r;
   logic [pLEN_WIDTH-1:0]   out_cnt_r;
   logic [AW-1:0]           wr_ptr_r;
   logic [AW-1:0]           rd_ptr_r;
   logic [AW:0]             occ_r;
   logic [pDATA_WIDTH-1:0]  mem_r [pDEPTH];
   logic                    frame_done_r;

   logic full_s;
   logic empty_s;
   logic in_ready_s;
   logic push_s;
   logic pop_s;
   logic last_s;
   logic start_s;
   logic done_s;

   // Handshake qualifiers; in_tready looks only at registered state, never at inputs.
   always_comb begin
      full_s     = (occ_r == OCC_FULL);
      empty_s    = (occ_r == OCC_ZERO);
      in_ready_s = (state_r == ST_RUN) && !full_s && (in_cnt_r < len_r);
      push_s     = bus.in_tvalid && in_ready_s;
      pop_s      = !empty_s && bus.ss_tready;
      last_s     = (out_cnt_r == (len_r - LEN_ONE));
      start_s    = (state_r == ST_IDLE) && cfg_start && (cfg_len != LEN_ZERO);
      done_s     = (state_r == ST_RUN) && pop_s && last_s;
   end

   // Next-state logic for the IDLE/RUN frame controller.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (done_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register, frame length latch and the one-cycle done pulse.
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         state_r      <= ST_IDLE;
         len_r        <= LEN_ZERO;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         frame_done_r <= done_s;
         if (start_s) begin
            len_r <= cfg_len;
         end
      end
   end

   // Frame counters: both are capped by len_r, so neither can wrap.
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         in_cnt_r  <= LEN_ZERO;
         out_cnt_r <= LEN_ZERO;
      end else if (start_s) begin
         in_cnt_r  <= LEN_ZERO;
         out_cnt_r <= LEN_ZERO;
      end else begin
         if (push_s) begin
            in_cnt_r <= in_cnt_r + LEN_ONE;
         end
         if (pop_s) begin
            out_cnt_r <= out_cnt_r + LEN_ONE;
         end
      end
   end

   // FIFO pointers and occupancy; a push and a pop together leave occupancy unchanged.
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         occ_r    <= OCC_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + OCC_ONE;
            2'b01:   occ_r <= occ_r - OCC_ONE;
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Sample storage; cleared on reset so ss_tdata reads zero afterwards.
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         for (int i = 0; i < pDEPTH; i++) begin
            mem_r[i] <= {pDATA_WIDTH{1'b0}};
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= bus.in_tdata;
      end
   end

   // Outputs are decoded purely from registers.
   always_comb begin
      busy          = (state_r == ST_RUN);
      frame_done    = frame_done_r;
      bus.in_tready = in_ready_s;
      bus.ss_tvalid = !empty_s;
      bus.ss_tdata  = mem_r[rd_ptr_r];
      bus.ss_tlast  = !empty_s && last_s;
   end

endmodule
